// File: rtl/game_input_ctrl.sv
// Board-side input front end for the game core: synchronises switches and buttons,
// debounces and edge-detects the buttons, and drives data/submit/nextLevel/attempts.

module game_input_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

   logic [7:0] count;
   logic       stable;
   logic       differs;
   logic       reached;

   assign differs = (level != stable);
   assign reached = differs && ((count + 8'd1) == LIMIT);
   // A press is accepted on the very edge where the stable level flips 0->1.
   assign rise    = reached && !stable;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 8'd0;
         stable <= 1'b0;
      end else if (!differs) begin
         count <= 8'd0;
      end else if (reached) begin
         stable <= ~stable;
         count  <= 8'd0;
      end else begin
         count <= count + 8'd1;
      end
   end

endmodule

module game_input_ctrl #(
   parameter int DATA_W          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              btn_submit_raw,
   input  logic              btn_next_raw,
   output logic [DATA_W-1:0] data,
   output logic              submit,
   output logic              nextLevel,
   output logic [CNT_W-1:0]  attempts,
   output logic              conflict
);

   logic [DATA_W-1:0] sw_meta;
   logic [DATA_W-1:0] sw_sync;
   logic              submit_meta;
   logic              submit_sync;
   logic              next_meta;
   logic              next_sync;
   logic              accept_submit;
   logic              accept_next;
   logic              pending;
   logic              fire_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta     <= '0;
         sw_sync     <= '0;
         submit_meta <= 1'b0;
         submit_sync <= 1'b0;
         next_meta   <= 1'b0;
         next_sync   <= 1'b0;
      end else begin
         sw_meta     <= sw_data;
         sw_sync     <= sw_meta;
         submit_meta <= btn_submit_raw;
         submit_sync <= submit_meta;
         next_meta   <= btn_next_raw;
         next_sync   <= next_meta;
      end
   end

   game_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
      .clk   (clk),
      .rst_n (rst_n),
      .level (submit_sync),
      .rise  (accept_submit)
   );

   game_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk   (clk),
      .rst_n (rst_n),
      .level (next_sync),
      .rise  (accept_next)
   );

   // Submit wins a tie; the deferred next-level press fires one cycle later.
   assign fire_next = pending | (accept_next & ~accept_submit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data      <= '0;
         submit    <= 1'b0;
         nextLevel <= 1'b0;
         conflict  <= 1'b0;
         pending   <= 1'b0;
         attempts  <= '0;
      end else begin
         submit    <= accept_submit;
         nextLevel <= fire_next;
         conflict  <= accept_submit & accept_next;
         pending   <= accept_submit & accept_next;
         if (accept_submit) begin
            data <= sw_sync;
         end
         // Clear-then-increment when a pending nextLevel meets a fresh submit.
         if (fire_next && accept_submit) begin
            attempts <= CNT_W'(1);
         end else if (fire_next) begin
            attempts <= '0;
         end else if (accept_submit && (attempts != '1)) begin
            attempts <= attempts + 1'b1;
         end
      end
   end

endmodule
